// File: rtl/gs_pkg.sv
// gs_pkg: shared constants and types for the banded Gauss-Seidel sequencer.
//   N          number of unknowns / rows
//   IDX_W      row index width
//   RUN        sweeps performed before the solution is streamed out
//   PIPE_LAT   issue-to-writeback latency of the compute unit
//   SWP_W      sweep counter width
//   gs_state_e sequencer states
//   NB_*       bit positions inside nbr_mask (M = minus offset, P = plus offset)
package gs_pkg;

    localparam int N        = 16;
    localparam int IDX_W    = 4;
    localparam int RUN      = 50;
    localparam int PIPE_LAT = 2;
    localparam int SWP_W    = 7;
    localparam int NB_W     = 6;

    localparam int NB_M1 = 0;
    localparam int NB_P1 = 1;
    localparam int NB_M2 = 2;
    localparam int NB_P2 = 3;
    localparam int NB_M3 = 4;
    localparam int NB_P3 = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        OUT  = 2'd3
    } gs_state_e;

endpackage

// File: rtl/gs_sequencer_if.sv
// gs_sequencer_if: control bundle between the sequencer and its surroundings.
//   in_en                 b_in beat strobe from the top-level handshake
//   b_we/b_addr/x_clr     register-file load controls
//   issue_valid/row_idx   compute-unit issue, nbr_mask gates the neighbour operands
//   wb_valid/wb_idx       x writeback
//   out_valid/out_idx     solution readout
//   busy/sweep_cnt        status
// modport master: the sequencer; modport slave: the environment.
interface gs_sequencer_if;
    import gs_pkg::*;

    logic                in_en;
    logic                b_we;
    logic [IDX_W-1:0]    b_addr;
    logic                x_clr;
    logic                issue_valid;
    logic [IDX_W-1:0]    row_idx;
    logic [NB_W-1:0]     nbr_mask;
    logic                wb_valid;
    logic [IDX_W-1:0]    wb_idx;
    logic                out_valid;
    logic [IDX_W-1:0]    out_idx;
    logic                busy;
    logic [SWP_W-1:0]    sweep_cnt;

    modport master (
        input  in_en,
        output b_we, b_addr, x_clr, issue_valid, row_idx, nbr_mask,
               wb_valid, wb_idx, out_valid, out_idx, busy, sweep_cnt
    );

    modport slave (
        output in_en,
        input  b_we, b_addr, x_clr, issue_valid, row_idx, nbr_mask,
               wb_valid, wb_idx, out_valid, out_idx, busy, sweep_cnt
    );
endinterface

// File: rtl/gs_wb_delay.sv
// gs_wb_delay: DEPTH-stage shift register carrying {valid, idx} from issue to
// writeback, modelling the compute-unit latency.
//   clk, reset (async, active-high)
//   in_valid/in_idx   issue strobe and row
//   out_valid/out_idx the same pair DEPTH cycles later
module gs_wb_delay
    import gs_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT,
    parameter int W     = IDX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx
);

    logic [DEPTH-1:0]        vld_r;
    logic [DEPTH-1:0][W-1:0] idx_r;

    // Shift the issue pair one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r <= '0;
            idx_r <= '0;
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_idx;
            for (int k = DEPTH - 1; k > 0; k--) begin
                vld_r[k] <= vld_r[k-1];
                idx_r[k] <= idx_r[k-1];
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_idx   = idx_r[DEPTH-1];

endmodule

// File: rtl/gs_sequencer.sv
// gs_sequencer: control FSM for the banded Gauss-Seidel solver datapath.
// Loads N b values, runs RUN sweeps of row issues with neighbour masks and
// delayed x writeback, then streams x out over N cycles.
//   clk, reset (async, active-high)
//   bus : gs_sequencer_if.master (in_en in; load/issue/writeback/out controls,
//         busy and sweep_cnt out)
// Build option GS_ISSUE_OVERLAP_EN: issue one row every cycle (chaotic
// relaxation) instead of one row every PIPE_LAT cycles.
module gs_sequencer
    import gs_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    gs_sequencer_if.master  bus
);

    localparam int PH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    gs_state_e         state_r;
    logic [IDX_W-1:0]  load_idx_r;
    logic [IDX_W-1:0]  row_idx_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic              issue_valid_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [SWP_W-1:0]  sweep_cnt_r;
    logic [SWP_W-1:0]  issue_sweep_r;  // sweeps fully issued (leads sweep_cnt_r)
    logic [PH_W-1:0]   phase_r;        // cycles since the last issue, mod PIPE_LAT

    logic              wb_valid_s;
    logic [IDX_W-1:0]  wb_idx_s;
    logic              last_issue_s;
    logic              issue_stop_s;
    logic              issue_next_s;
    logic              final_wb_s;
    logic [PH_W-1:0]   phase_next_s;
    logic [IDX_W-1:0]  row_next_s;
    logic              b_we_s;
    logic              x_clr_s;
    logic [NB_W-1:0]   nbr_mask_s;

    // Offset k is valid when row i+/-k stays inside 0..N-1.
    function automatic logic [NB_W-1:0] nbr_mask_f(input logic [IDX_W-1:0] i);
        logic [NB_W-1:0] m;
        m        = '0;
        m[NB_M1] = (i >= IDX_W'(1));
        m[NB_P1] = (i <= IDX_W'(N - 2));
        m[NB_M2] = (i >= IDX_W'(2));
        m[NB_P2] = (i <= IDX_W'(N - 3));
        m[NB_M3] = (i >= IDX_W'(3));
        m[NB_P3] = (i <= IDX_W'(N - 4));
        return m;
    endfunction

    gs_wb_delay #(.DEPTH(PIPE_LAT), .W(IDX_W)) u_wb_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid_r),
        .in_idx    (row_idx_r),
        .out_valid (wb_valid_s),
        .out_idx   (wb_idx_s)
    );

    // Issue pacing and end-of-run detection.
    always_comb begin
        last_issue_s = issue_valid_r && (row_idx_r == IDX_W'(N - 1)) &&
                       (issue_sweep_r == SWP_W'(RUN - 1));
        issue_stop_s = (issue_sweep_r == SWP_W'(RUN)) || last_issue_s;
        phase_next_s = (phase_r == PH_W'(PIPE_LAT - 1)) ? '0 : phase_r + 1'b1;
`ifdef GS_ISSUE_OVERLAP_EN
        issue_next_s = !issue_stop_s;
`else
        issue_next_s = !issue_stop_s && (phase_next_s == '0);
`endif
        row_next_s   = issue_valid_r ? row_idx_r + 1'b1 : row_idx_r;
        final_wb_s   = wb_valid_s && (wb_idx_s == IDX_W'(N - 1)) &&
                       (sweep_cnt_r == SWP_W'(RUN - 1));
    end

    // b-load strobes follow in_en in the same cycle; the beat in IDLE also clears x.
    always_comb begin
        b_we_s  = 1'b0;
        x_clr_s = 1'b0;
        if (!reset && bus.in_en && ((state_r == IDLE) || (state_r == LOAD))) begin
            b_we_s  = 1'b1;
            x_clr_s = (state_r == IDLE);
        end else begin
            b_we_s  = 1'b0;
            x_clr_s = 1'b0;
        end
    end

    // Mask is only driven while a row is actually being issued.
    always_comb begin
        nbr_mask_s = '0;
        if (issue_valid_r) begin
            nbr_mask_s = nbr_mask_f(row_idx_r);
        end else begin
            nbr_mask_s = '0;
        end
    end

    // Sequencer FSM with registered strobes and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            load_idx_r    <= '0;
            row_idx_r     <= '0;
            out_idx_r     <= '0;
            issue_valid_r <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            sweep_cnt_r   <= '0;
            issue_sweep_r <= '0;
            phase_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    issue_valid_r <= 1'b0;
                    out_valid_r   <= 1'b0;
                    if (bus.in_en) begin
                        state_r       <= LOAD;
                        busy_r        <= 1'b1;
                        load_idx_r    <= IDX_W'(1);
                        sweep_cnt_r   <= '0;
                        issue_sweep_r <= '0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.in_en) begin
                        if (load_idx_r == IDX_W'(N - 1)) begin
                            state_r       <= ITER;
                            load_idx_r    <= '0;
                            issue_valid_r <= 1'b1;
                            row_idx_r     <= '0;
                            phase_r       <= '0;
                        end else begin
                            load_idx_r <= load_idx_r + 1'b1;
                        end
                    end
                end
                ITER: begin
                    issue_valid_r <= issue_next_s;
                    row_idx_r     <= row_next_s;
                    phase_r       <= phase_next_s;
                    if (issue_valid_r && (row_idx_r == IDX_W'(N - 1)) &&
                        (issue_sweep_r != SWP_W'(RUN))) begin
                        issue_sweep_r <= issue_sweep_r + 1'b1;
                    end
                    if (wb_valid_s && (wb_idx_s == IDX_W'(N - 1)) &&
                        (sweep_cnt_r != SWP_W'(RUN))) begin
                        sweep_cnt_r <= sweep_cnt_r + 1'b1;
                    end
                    if (final_wb_s) begin
                        state_r     <= OUT;
                        out_valid_r <= 1'b1;
                        out_idx_r   <= '0;
                    end
                end
                OUT: begin
                    if (out_idx_r == IDX_W'(N - 1)) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        out_idx_r   <= '0;
                        busy_r      <= 1'b0;
                    end else begin
                        out_idx_r <= out_idx_r + 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    issue_valid_r <= 1'b0;
                    out_valid_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.b_we        = b_we_s;
    assign bus.b_addr      = load_idx_r;
    assign bus.x_clr       = x_clr_s;
    assign bus.issue_valid = issue_valid_r;
    assign bus.row_idx     = row_idx_r;
    assign bus.nbr_mask    = nbr_mask_s;
    assign bus.wb_valid    = wb_valid_s;
    assign bus.wb_idx      = wb_idx_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_idx     = out_idx_r;
    assign bus.busy        = busy_r;
    assign bus.sweep_cnt   = sweep_cnt_r;

endmodule
